// File: rtl/fpga_irq_source.sv
// HPS interrupt source: synchronizes and debounces active-low keys, captures presses,
// and raises a level irq for unmasked captured presses; Avalon-MM slave for DATA/MASK/EDGE/COUNT.
module fpga_irq_source #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] key_n,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  output logic [31:0]      avs_readdata,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  input  logic [3:0]       avs_byteenable,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q1, sync_q2;
  logic [WIDTH-1:0] stable, stable_prev;
  logic [WIDTH-1:0] edge_bits, mask_bits;
  logic [WIDTH-1:0] press, clr_bits, edge_next;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [31:0]      count;
  logic [31:0]      rd_mux;
  logic             wr_mask, wr_edge, wr_count;
  logic             irq_next, irq_rise;

  // Bus bits wider than the key field carry no meaning here.
  logic unused_bus;
  assign unused_bus = ^{avs_writedata[31:WIDTH], avs_byteenable[3:1]};

  // Stage 0: two-flop synchronizer; idle level is released (1).
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= key_n;
      sync_q2 <= sync_q1;
    end
  end

  // Stage 1: per-bit debounce; any return to the accepted level restarts the count.
  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        stable[i] <= 1'b1;
        cnt[i]    <= '0;
      end else if (sync_q2[i] == stable[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == CNT_LAST) begin
        stable[i] <= sync_q2[i];
        cnt[i]    <= '0;
      end else begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign wr_mask  = avs_write && (avs_address == 2'd1) && avs_byteenable[0];
  assign wr_edge  = avs_write && (avs_address == 2'd2) && avs_byteenable[0];
  assign wr_count = avs_write && (avs_address == 2'd3);

  // A press in the same cycle as its W1C wins, so OR it in after the clear.
  assign press     = stable_prev & ~stable;
  assign clr_bits  = wr_edge ? avs_writedata[WIDTH-1:0] : '0;
  assign edge_next = (edge_bits & ~clr_bits) | press;
  assign irq_next  = |(edge_bits & mask_bits);
  assign irq_rise  = irq_next & ~irq;

  // Stage 2: press capture, mask, irq and its rise counter.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_prev <= '1;
      edge_bits   <= '0;
      mask_bits   <= '0;
      irq         <= 1'b0;
      count       <= '0;
    end else begin
      stable_prev <= stable;
      edge_bits   <= edge_next;
      irq         <= irq_next;
      if (wr_mask) mask_bits <= avs_writedata[WIDTH-1:0];
      if (wr_count)                      count <= {31'd0, irq_rise};
      else if (irq_rise && count != '1)  count <= count + 32'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd1:    rd_mux[WIDTH-1:0] = mask_bits;
      2'd2:    rd_mux[WIDTH-1:0] = edge_bits;
      default: rd_mux            = count;
    endcase
  end

  // Stage 3: read data, latency one, held between reads.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) avs_readdata <= '0;
    else if (avs_read)  avs_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_fpga_irq_source.sv
// Directed bench for fpga_irq_source with DEBOUNCE_CYCLES=4, WIDTH=4.
module tb_fpga_irq_source;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [3:0]  key_n;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  fpga_irq_source #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .key_n(key_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_byteenable(avs_byteenable), .irq(irq)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    tick();
    avs_write = 1'b0; avs_byteenable = 4'h0; avs_writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  initial begin
    reset_reset_n = 1'b0; key_n = 4'hF; avs_address = '0; avs_read = 1'b0;
    avs_write = 1'b0; avs_writedata = '0; avs_byteenable = '0;
    tick(); tick();
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata", avs_readdata, 32'd0);
    reset_reset_n = 1'b1;
    bus_read(2'd0, rd); check("rst_data", rd, 32'h0000000F);
    bus_read(2'd1, rd); check("rst_mask", rd, 32'h0);
    bus_read(2'd2, rd); check("rst_edge", rd, 32'h0);
    bus_read(2'd3, rd); check("rst_count", rd, 32'h0);
    check("rst_irq_after", {31'd0, irq}, 32'd0);

    // Basic press on key 0: edge captured at edge 6, irq register set at edge 7.
    bus_write(2'd1, 32'h1, 4'hF);
    key_n[0] = 1'b0;
    repeat (7) tick();
    check("press_irq_early", {31'd0, irq}, 32'd0);
    tick();
    check("press_irq_set", {31'd0, irq}, 32'd1);
    bus_read(2'd2, rd); check("press_edge", rd, 32'h1);
    bus_read(2'd3, rd); check("press_count", rd, 32'h1);
    bus_read(2'd0, rd); check("press_data", rd, 32'hE);
    bus_write(2'd2, 32'h1, 4'h1);
    tick();
    check("ack_irq_low", {31'd0, irq}, 32'd0);
    bus_read(2'd2, rd); check("ack_edge", rd, 32'h0);
    key_n[0] = 1'b1;
    repeat (10) tick();

    // Glitch shorter than the debounce window.
    key_n[1] = 1'b0;
    repeat (3) tick();
    key_n[1] = 1'b1;
    repeat (10) tick();
    bus_read(2'd0, rd); check("glitch_data", rd, 32'hF);
    bus_read(2'd2, rd); check("glitch_edge", rd, 32'h0);
    check("glitch_irq", {31'd0, irq}, 32'd0);

    // Accepted press while masked, then unmask.
    bus_write(2'd1, 32'h0, 4'hF);
    key_n[1] = 1'b0;
    repeat (6) tick();
    key_n[1] = 1'b1;
    repeat (10) tick();
    bus_read(2'd2, rd); check("masked_edge", rd, 32'h2);
    check("masked_irq", {31'd0, irq}, 32'd0);
    bus_write(2'd1, 32'h2, 4'h1);
    check("unmask_irq_same", {31'd0, irq}, 32'd0);
    tick();
    check("unmask_irq_next", {31'd0, irq}, 32'd1);

    // W1C of bits 1 and 2 on the edge where the key 2 press lands: bit 2 survives.
    bus_write(2'd1, 32'h6, 4'h1);
    key_n[2] = 1'b0;
    repeat (6) tick();
    bus_write(2'd2, 32'h6, 4'h1);
    check("setwin_irq0", {31'd0, irq}, 32'd1);
    tick();
    check("setwin_irq1", {31'd0, irq}, 32'd1);
    bus_read(2'd2, rd); check("setwin_edge", rd, 32'h4);
    key_n[2] = 1'b1;
    repeat (10) tick();
    bus_write(2'd2, 32'h4, 4'h1);
    tick();
    check("setwin_ack_irq", {31'd0, irq}, 32'd0);

    // COUNT: clear with no byte enables, then four press/ack cycles on key 3.
    bus_write(2'd1, 32'h8, 4'h1);
    bus_write(2'd3, 32'h0, 4'h0);
    bus_read(2'd3, rd); check("count_clr", rd, 32'h0);
    for (int k = 0; k < 4; k++) begin
      key_n[3] = 1'b0;
      repeat (10) tick();
      check("count_loop_irq", {31'd0, irq}, 32'd1);
      bus_write(2'd2, 32'h8, 4'h1);
      key_n[3] = 1'b1;
      repeat (10) tick();
    end
    bus_read(2'd3, rd); check("count_four", rd, 32'h4);

    // COUNT clear on the same edge as an irq rise.
    key_n[3] = 1'b0;
    repeat (7) tick();
    bus_write(2'd3, 32'h0, 4'hF);
    check("coincide_irq", {31'd0, irq}, 32'd1);
    bus_read(2'd3, rd); check("coincide_count", rd, 32'h1);
    bus_write(2'd1, 32'h0, 4'h0);
    bus_read(2'd1, rd); check("mask_be0", rd, 32'h8);
    bus_write(2'd0, 32'h0, 4'hF);
    bus_read(2'd0, rd); check("data_ro", rd, 32'h7);

    // Reset while irq is high and key 0 is mid-debounce.
    key_n[0] = 1'b0;
    repeat (3) tick();
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    reset_reset_n = 1'b0;
    #1;
    check("async_irq", {31'd0, irq}, 32'd0);
    check("async_rdata", avs_readdata, 32'h0);
    tick(); tick();
    reset_reset_n = 1'b1;
    bus_read(2'd0, rd); check("rr_data", rd, 32'hF);
    bus_read(2'd1, rd); check("rr_mask", rd, 32'h0);
    bus_read(2'd2, rd); check("rr_edge", rd, 32'h0);
    bus_read(2'd3, rd); check("rr_count", rd, 32'h0);
    bus_read(2'd0, rd); check("rr_data4", rd, 32'hF);
    bus_read(2'd0, rd); check("rr_data5", rd, 32'hF);
    bus_read(2'd0, rd); check("rr_data6", rd, 32'h6);
    bus_read(2'd2, rd); check("rr_edge7", rd, 32'h9);
    check("rr_irq", {31'd0, irq}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
